// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: shared state encoding and tick constants for the delay scheduler
package delay_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int DEF_WIDTH   = 12;
    localparam int TICKS_2S    = 4000;
    localparam int TICKS_1S    = 2000;
    localparam int TICKS_500MS = 1000;

endpackage

// File: rtl/delay_scheduler_rr_pick.sv
// rr_pick: round-robin winner search starting at ptr and wrapping upward
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    // scan from the farthest offset down so the nearest set bit after ptr wins
    always_comb begin
        logic [PW-1:0] j;
        j       = '0;
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = PW'((int'(ptr_i) + i) % NREQ);
            if (req_i[j]) idx_o = j;
        end
    end

endmodule

// File: rtl/delay_scheduler.sv
// delay_scheduler: shares one tick counter among requesters, granting timed waits round-robin
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 3
) (
    input  logic                  clk_2K,
    input  logic                  i_Reset_n,
    input  logic                  i_Abort,
    input  logic [NREQ-1:0]       i_Req,
    input  logic [NREQ*WIDTH-1:0] i_Dur,
    output logic [NREQ-1:0]       o_Grant,
    output logic [NREQ-1:0]       o_Done,
    output logic                  o_Busy,
    output logic [WIDTH-1:0]      o_Count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, own_q, own_d, win_idx, ptr_nxt;
    logic              win_vld, own_req;
    logic [WIDTH-1:0]  dur_q, dur_d, count_q, count_d, win_dur;
    logic [NREQ-1:0]   grant_q, grant_d;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i   (i_Req),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_vld)
    );

    assign win_dur = i_Dur[int'(win_idx)*WIDTH +: WIDTH];
    assign own_req = i_Req[own_q];
    assign ptr_nxt = (own_q == PW'(NREQ - 1)) ? '0 : own_q + 1'b1;

    // state and datapath registers
    always_ff @(posedge clk_2K or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            dur_q   <= '0;
            count_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            dur_q   <= dur_d;
            count_q <= count_d;
            grant_q <= grant_d;
        end
    end

    // next state: abort beats everything, a dropped request cancels before completion
    always_comb begin
        state_d = state_q;
        if (i_Abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (win_vld) state_d = (win_dur == '0) ? S_DONE : S_RUN;
                S_RUN:   state_d = !own_req ? S_IDLE : (count_q == dur_q - 1'b1) ? S_DONE : S_RUN;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // datapath next values derived from the state transition being taken
    always_comb begin
        ptr_d   = (state_d == S_IDLE && state_q != S_IDLE && !i_Abort) ? ptr_nxt : ptr_q;
        own_d   = (state_q == S_IDLE && state_d != S_IDLE) ? win_idx : own_q;
        dur_d   = (state_q == S_IDLE && state_d != S_IDLE) ? win_dur : dur_q;
        count_d = (state_d == S_IDLE || state_q == S_IDLE) ? '0 : count_q + 1'b1;
        grant_d = (state_d == S_IDLE) ? '0 : (state_q == S_IDLE) ? NREQ'(1) << win_idx : grant_q;
    end

    // outputs come straight from registers only
    always_comb begin
        o_Grant = grant_q;
        o_Done  = (state_q == S_DONE) ? grant_q : '0;
        o_Busy  = (state_q != S_IDLE);
        o_Count = count_q;
    end

endmodule

// File: doc/delay_scheduler.md
Name: delay_scheduler

Overview:
- Shares one 2 kHz delay counter between NREQ game-FSM requesters, such as card-deal pacing, the result-display hold and the LED blink.
- Each requester asks for a timed wait of D ticks. The block grants requesters one at a time in round-robin order, runs the wait and pulses a per-requester done.
- Sits between the game control FSMs and the shared tick domain. It replaces the ad-hoc per-FSM delay counters.

Parameters:
- WIDTH, 12, width of the duration and count. 4000 ticks equals 2 s at 2 kHz.
- NREQ, 3, number of requesters (2..8).

Ports:
- clk_2K  input  1  2 kHz system clock.
- i_Reset_n  input  1  asynchronous active-low reset.
- i_Abort  input  1  synchronous abort from the debounced game-reset button.
- i_Req  input  NREQ  per-requester level request; held until done.
- i_Dur  input  NREQ*WIDTH  flattened durations; slice k is i_Dur[k*WIDTH +: WIDTH].
- o_Grant  output  NREQ  one-hot current owner; all zero when idle.
- o_Done  output  NREQ  one-cycle pulse to the owner when its wait expires.
- o_Busy  output  1  high in RUN or DONE.
- o_Count  output  WIDTH  elapsed ticks of the current wait.

Behaviour:
- Reset (i_Reset_n low, asynchronous):
  - state=IDLE, o_Grant=0, o_Done=0, o_Busy=0, o_Count=0.
  - Round-robin pointer ptr=0.
  - Latched duration = 0.
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - If any i_Req bit is high, pick winner k = first set bit searching from ptr upward, with wrap.
  - Latch D = i_Dur[k] and clear count.
  - Next state is RUN, or DONE if D == 0.
  - o_Grant[k] rises on that same edge.
- RUN:
  - o_Count increments by 1 each edge.
  - When o_Count == D-1 at an edge, go to DONE with o_Count = D.
  - RUN therefore lasts exactly D cycles.
- DONE:
  - Lasts one cycle.
  - o_Done[k]=1, o_Grant[k] still high, o_Count holds D.
  - Next state IDLE, o_Grant cleared, ptr = (k+1) mod NREQ, o_Count = 0.
  - A wait-to-wait gap of one IDLE cycle is mandatory.
- Latency: request sampled at edge n → o_Grant at n, o_Done high during cycle n+D+1. With D=0, o_Done is high during cycle n+1.
- The duration is latched at grant. Changes to i_Dur[k] during RUN are ignored.
- Cancel: i_Req[k] low while in RUN or DONE → next edge goes to IDLE, no o_Done, o_Count=0, ptr=(k+1) mod NREQ.
- i_Abort high → next edge goes to IDLE from any state.
  - No o_Done is issued and ptr is unchanged.
  - Abort has priority over cancel, completion and new grants.
  - While i_Abort is held, no grant is issued.
- Requests from non-owners are ignored until IDLE. Their i_Req stays pending.
- If an owner re-requests immediately after its done, the others take priority via ptr. With a single requester, it is re-granted after the one IDLE cycle.
- Count wrap is impossible, since D ≤ 2^WIDTH-1 and the count stops at D. D = 2^WIDTH-1 must work without overflow.
- o_Busy = (state != IDLE).
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Package delay_sched_pkg:
  - state encodings S_IDLE, S_RUN, S_DONE
  - DEF_WIDTH=12
  - TICKS_2S=4000, TICKS_1S=2000, TICKS_500MS=1000
- One sub-module, rr_pick: combinational, taking req[NREQ] and ptr and returning winner index plus valid. Unit-testable on its own.
- Top: FSM, duration latch, counter and output registers.

Test Plan:
- Reset with i_Req=3'b111 held: all outputs 0 until release; first grant goes to requester 0, o_Grant=3'b001.
- Req0 alone, D=5: o_Grant=001 for 6 cycles; o_Done=001 on the 6th cycle with o_Count=5; IDLE the next cycle.
- All three requesting, D=2 each: grant order 0,1,2,0. Each done arrives 3 cycles after its grant, with a 1-cycle IDLE gap between wait periods.
- Req1 with D=0: o_Done=010 on the cycle after the grant, and RUN never entered.
- Req2, D=4000, i_Abort pulsed at count 1500: IDLE next edge, no o_Done, o_Count=0; then req0 and req2 pending → requester 2 granted, since ptr is unchanged.
- Req0, D=10, i_Req[0] dropped at count 3: no o_Done; a pending req1 is granted on the following IDLE cycle.
